// File: rtl/month_year_counter.sv
// Month/year calendar stage: advances on end-of-month midnight, supports push-button edit.
// Optional macro DAY_CLAMP_EN adds a day-clamp request after month/year edits.
module month_year_counter #(
   parameter int          YEAR_MIN   = 2000,
   parameter int          YEAR_MAX   = 2199,
   parameter logic [2:0]  MODE_DAY   = 3'b110,
   parameter logic [2:0]  MODE_MONTH = 3'b101,
   parameter logic [2:0]  MODE_YEAR  = 3'b100
) (
   input  logic        clk_1Hz,
   input  logic        rst,
   input  logic [5:0]  sec,
   input  logic [5:0]  min,
   input  logic [4:0]  hour,
   input  logic [4:0]  day,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic [2:0]  mode,
   output logic [3:0]  mont,
   output logic [12:0] year,
   output logic [4:0]  days_in_month,
   output logic        leap,
   output logic        year_tick,
   output logic        day_fix_valid,
   output logic [4:0]  day_fix
);

   localparam logic [12:0] LP_YMIN = YEAR_MIN[12:0];
   localparam logic [12:0] LP_YMAX = YEAR_MAX[12:0];

   function automatic logic is_leap(input logic [12:0] y);
      return ((y % 13'd4 == 13'd0) && (y % 13'd100 != 13'd0)) || (y % 13'd400 == 13'd0);
   endfunction

   function automatic logic [4:0] dim_of(input logic [3:0] m, input logic [12:0] y);
      logic [4:0] d;
      case (m)
         4'd2:                      d = is_leap(y) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   d = 5'd30;
         default:                   d = 5'd31;
      endcase
      return d;
   endfunction

   logic [3:0]  r_mont;
   logic [12:0] r_year;
   logic        r_year_tick;

   logic [3:0]  w_mont_nxt;
   logic [12:0] w_year_nxt;
   logic        w_rollover;
   logic        w_midnight;
   logic        w_eom;

   assign mont          = r_mont;
   assign year          = r_year;
   assign year_tick     = r_year_tick;
   assign leap          = is_leap(r_year);
   assign days_in_month = dim_of(r_mont, r_year);

   assign w_midnight = (sec == 6'd59) && (min == 6'd59) && (hour == 5'd23);
   // A day past the month end (left by an edit) never matches, so the month holds.
   assign w_eom      = w_midnight && (day == days_in_month);

   always_comb begin
      w_mont_nxt = r_mont;
      w_year_nxt = r_year;
      w_rollover = 1'b0;
      if (mode == MODE_MONTH) begin
         if (!btn_up)
            w_mont_nxt = (r_mont == 4'd12) ? 4'd1 : r_mont + 4'd1;
         else if (!btn_down)
            w_mont_nxt = (r_mont == 4'd1) ? 4'd12 : r_mont - 4'd1;
      end else if (mode == MODE_YEAR) begin
         if (!btn_up)
            w_year_nxt = (r_year == LP_YMAX) ? LP_YMIN : r_year + 13'd1;
         else if (!btn_down)
            w_year_nxt = (r_year == LP_YMIN) ? LP_YMAX : r_year - 13'd1;
      end else if ((mode != MODE_DAY) && w_eom) begin
         if (r_mont == 4'd12) begin
            w_mont_nxt = 4'd1;
            w_year_nxt = (r_year == LP_YMAX) ? LP_YMIN : r_year + 13'd1;
            w_rollover = 1'b1;
         end else begin
            w_mont_nxt = r_mont + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_1Hz) begin
      if (rst) begin
         r_mont      <= 4'd1;
         r_year      <= LP_YMIN;
         r_year_tick <= 1'b0;
      end else begin
         r_mont      <= w_mont_nxt;
         r_year      <= w_year_nxt;
         r_year_tick <= w_rollover;
      end
   end

`ifdef DAY_CLAMP_EN
   logic       r_fix_valid;
   logic [4:0] r_fix;
   logic       w_edit_chg;
   logic [4:0] w_dim_nxt;

   assign w_edit_chg = ((mode == MODE_MONTH) || (mode == MODE_YEAR)) &&
                       ((w_mont_nxt != r_mont) || (w_year_nxt != r_year));
   assign w_dim_nxt  = dim_of(w_mont_nxt, w_year_nxt);

   // Request is registered alongside the new month/year so the day stage sees both together.
   always_ff @(posedge clk_1Hz) begin
      if (rst) begin
         r_fix_valid <= 1'b0;
         r_fix       <= 5'd1;
      end else begin
         r_fix_valid <= w_edit_chg && (day > w_dim_nxt);
         if (w_edit_chg && (day > w_dim_nxt))
            r_fix <= w_dim_nxt;
      end
   end

   assign day_fix_valid = r_fix_valid;
   assign day_fix       = r_fix;
`else
   assign day_fix_valid = 1'b0;
   assign day_fix       = 5'd1;
`endif

endmodule

// File: tb/tb_month_year_counter.sv
// Directed bench for month_year_counter: reset, edits, wraps, end-of-month advance, year_tick.
module tb_month_year_counter;

   logic        clk_1Hz = 1'b0;
   logic        rst;
   logic [5:0]  sec;
   logic [5:0]  min;
   logic [4:0]  hour;
   logic [4:0]  day;
   logic        btn_up;
   logic        btn_down;
   logic [2:0]  mode;
   logic [3:0]  mont;
   logic [12:0] year;
   logic [4:0]  days_in_month;
   logic        leap;
   logic        year_tick;
   logic        day_fix_valid;
   logic [4:0]  day_fix;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_mont;
   int exp_year;

   localparam logic [2:0] MD_DAY   = 3'b110;
   localparam logic [2:0] MD_MONTH = 3'b101;
   localparam logic [2:0] MD_YEAR  = 3'b100;

   month_year_counter dut (
      .clk_1Hz       (clk_1Hz),
      .rst           (rst),
      .sec           (sec),
      .min           (min),
      .hour          (hour),
      .day           (day),
      .btn_up        (btn_up),
      .btn_down      (btn_down),
      .mode          (mode),
      .mont          (mont),
      .year          (year),
      .days_in_month (days_in_month),
      .leap          (leap),
      .year_tick     (year_tick),
      .day_fix_valid (day_fix_valid),
      .day_fix       (day_fix)
   );

   always #5 clk_1Hz = ~clk_1Hz;

   task automatic check(input string tag, input int observed, input int expected);
      n_checks++;
      if (observed == expected) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk_1Hz);
      #1;
   endtask

   task automatic set_time(input bit at_midnight);
      if (at_midnight) begin
         hour = 5'd23; min = 6'd59; sec = 6'd59;
      end else begin
         hour = 5'd12; min = 6'd0;  sec = 6'd0;
      end
   endtask

   task automatic idle_inputs();
      btn_up = 1'b1; btn_down = 1'b1; mode = 3'b000;
      set_time(1'b0);
   endtask

   initial begin
      rst = 1'b1; day = 5'd1;
      idle_inputs();
      tick();
      check("reset_mont", mont, 1);
      check("reset_year", year, 2000);
      check("reset_dim", days_in_month, 31);
      check("reset_leap", leap, 1);
      check("reset_year_tick", year_tick, 0);
      check("reset_fix_valid", day_fix_valid, 0);
      check("reset_fix", day_fix, 1);

      rst = 1'b0;
      tick();
      check("hold_mont", mont, 1);

      // Month up held 13 ticks: 2..12,1,2
      mode = MD_MONTH; btn_up = 1'b0;
      exp_mont = 1;
      for (int i = 0; i < 13; i++) begin
         tick();
         exp_mont = (exp_mont == 12) ? 1 : exp_mont + 1;
         check("month_up_seq", mont, exp_mont);
      end
      btn_down = 1'b0;
      tick();
      check("both_pressed_up_wins", mont, 3);
      check("month_edit_year_same", year, 2000);
      btn_up = 1'b1; day = 5'd31;
      tick();
      check("month_down", mont, 2);
      check("feb_2000_dim", days_in_month, 29);
`ifdef DAY_CLAMP_EN
      check("clamp_valid", day_fix_valid, 1);
      check("clamp_value", day_fix, 29);
`else
      check("noclamp_valid", day_fix_valid, 0);
      check("noclamp_value", day_fix, 1);
`endif
      idle_inputs();
      tick();
      check("clamp_valid_drop", day_fix_valid, 0);

      // Feb 2000 is leap: day 28 at midnight is not end of month
      day = 5'd28; set_time(1'b1);
      tick();
      check("feb28_leap_hold", mont, 2);

      // Year up 100 ticks -> 2100
      idle_inputs(); mode = MD_YEAR; btn_up = 1'b0;
      exp_year = 2000;
      for (int i = 0; i < 100; i++) begin
         tick();
         exp_year++;
         check("year_up_seq", year, exp_year);
      end
      check("year_edit_mont_same", mont, 2);
      check("leap_2100", leap, 0);
      check("feb_2100_dim", days_in_month, 28);

      idle_inputs(); day = 5'd28; set_time(1'b1);
      tick();
      check("feb28_2100_advance", mont, 3);
      check("feb28_2100_year", year, 2100);
      check("mar_dim", days_in_month, 31);
      check("advance_no_tick", year_tick, 0);

      idle_inputs(); mode = MD_YEAR; btn_up = 1'b0;
      for (int i = 0; i < 99; i++) tick();
      check("year_2199", year, 2199);
      tick();
      check("year_up_wrap", year, 2000);
      check("year_edit_no_tick", year_tick, 0);
      btn_up = 1'b1; btn_down = 1'b0;
      tick();
      check("year_down_wrap", year, 2199);
      tick(); tick(); tick();
      check("year_2196", year, 2196);
      check("leap_2196", leap, 1);
      btn_up = 1'b0; btn_down = 1'b1;
      tick(); tick(); tick();
      check("year_back_2199", year, 2199);

      // Month 3 -> 12, then December end-of-month rollover at YEAR_MAX
      idle_inputs(); mode = MD_MONTH; btn_up = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("month_12", mont, 12);
      idle_inputs(); day = 5'd31; set_time(1'b1);
      tick();
      check("rollover_mont", mont, 1);
      check("rollover_year", year, 2000);
      check("rollover_tick", year_tick, 1);
      set_time(1'b0);
      tick();
      check("tick_one_cycle", year_tick, 0);
      check("post_rollover_mont", mont, 1);

      // Day edit freezes auto-advance
      mode = MD_DAY; day = 5'd31; set_time(1'b1); btn_up = 1'b0;
      tick();
      check("mode_day_hold", mont, 1);
      check("mode_day_year_hold", year, 2000);

      // Day beyond month length never advances
      idle_inputs(); mode = MD_MONTH; btn_up = 1'b0;
      tick(); tick(); tick();
      check("month_4", mont, 4);
      check("apr_dim", days_in_month, 30);
      idle_inputs(); day = 5'd31; set_time(1'b1);
      tick();
      check("day_over_hold", mont, 4);

      // Reset wins over an edit on the same edge
      idle_inputs(); rst = 1'b1; mode = MD_MONTH; btn_up = 1'b0;
      tick();
      check("reset_priority_mont", mont, 1);
      check("reset_priority_year", year, 2000);
      rst = 1'b0; idle_inputs();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
